// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state
// encodings, PC step, reset vector, stall-counter ceiling and the
// next-PC selection record passed from pc_next_mux to pc_sequencer.
package pc_seq_pkg;

  // FSM state encodings; 3 is never entered and recovers to BOOT
  localparam logic [1:0] ST_BOOT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STALL   = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] RESET_VECTOR  = 32'h0000_0000;
  localparam logic [7:0]  STALL_CNT_MAX = 8'd255;

  // Result of the combinational next-PC decision
  typedef struct packed {
    logic        taken;       // a control transfer is requested
    logic        misaligned;  // requested transfer target is not word aligned
    logic [31:0] next_pc;     // PC to load if this edge commits
  } next_sel_t;

  // Instruction fetch is word based, so the low two target bits are dropped
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline and the PC sequencer.
// Optional feature macro: PC_SEQ_BNE_EN adds the BRANCH_NE request line.
// The slave modport is the sequencer's view; master is the pipeline's.
interface pc_sequencer_if;

  logic        BUSYWAIT;
  logic        JUMP;
  logic        BRANCH_EQ;
  logic        ZERO;
`ifdef PC_SEQ_BNE_EN
  logic        BRANCH_NE;
`endif
  logic [31:0] TARGET;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        REDIRECT;
  logic        MISALIGN;
  logic [7:0]  STALL_CNT;
  logic [1:0]  STATE;

`ifdef PC_SEQ_BNE_EN
  modport master (
    output BUSYWAIT, JUMP, BRANCH_EQ, ZERO, BRANCH_NE, TARGET,
    input  PC, PC_PLUS4, REDIRECT, MISALIGN, STALL_CNT, STATE
  );

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH_EQ, ZERO, BRANCH_NE, TARGET,
    output PC, PC_PLUS4, REDIRECT, MISALIGN, STALL_CNT, STATE
  );
`else
  modport master (
    output BUSYWAIT, JUMP, BRANCH_EQ, ZERO, TARGET,
    input  PC, PC_PLUS4, REDIRECT, MISALIGN, STALL_CNT, STATE
  );

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH_EQ, ZERO, TARGET,
    output PC, PC_PLUS4, REDIRECT, MISALIGN, STALL_CNT, STATE
  );
`endif

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential PC+4 (wrapping modulo 2^32)
// or the word-aligned jump/branch target, plus the alignment check on the
// requested target. Optional feature macro: PC_SEQ_BNE_EN adds a
// branch-on-not-equal request that is taken when ZERO is low.
module pc_next_mux
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic        branch_eq,
  input  logic        zero,
`ifdef PC_SEQ_BNE_EN
  input  logic        branch_ne,
`endif
  input  logic [31:0] target,
  output logic [31:0] pc_plus4,
  output next_sel_t   sel
);

  logic cond_branch;

  // Conditional branch outcome from the ALU zero flag
  always_comb begin
    cond_branch = branch_eq & zero;
`ifdef PC_SEQ_BNE_EN
    cond_branch = cond_branch | (branch_ne & ~zero);
`endif
  end

  // Jump wins over any branch; both redirect to the same target address
  always_comb begin
    pc_plus4       = pc + PC_STEP;
    sel.taken      = 1'b0;
    sel.misaligned = 1'b0;
    sel.next_pc    = pc_plus4;
    if (jump) begin
      sel.taken   = 1'b1;
      sel.next_pc = word_align(target);
    end else if (cond_branch) begin
      sel.taken   = 1'b1;
      sel.next_pc = word_align(target);
    end
    sel.misaligned = sel.taken & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a BOOT/RUN/STALL FSM. The PC holds while
// the memory stalls, otherwise advances by 4 or loads a jump/branch target.
// Also produces a one-cycle redirect pulse, a sticky misaligned-target flag
// and a saturating stall-cycle counter.
// Optional feature macro: PC_SEQ_BNE_EN (adds BRANCH_NE to the bus).
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  pc_sequencer_if.slave  bus
);

  logic [31:0] pc_reg,        pc_next;
  logic [1:0]  state_reg,     state_next;
  logic        redirect_reg,  redirect_next;
  logic        misalign_reg,  misalign_next;
  logic [7:0]  stall_cnt_reg, stall_cnt_next;

  logic [31:0] pc_plus4;
  next_sel_t   sel;

  pc_next_mux u_next_mux (
    .pc        (pc_reg),
    .jump      (bus.JUMP),
    .branch_eq (bus.BRANCH_EQ),
    .zero      (bus.ZERO),
`ifdef PC_SEQ_BNE_EN
    .branch_ne (bus.BRANCH_NE),
`endif
    .target    (bus.TARGET),
    .pc_plus4  (pc_plus4),
    .sel       (sel)
  );

  // FSM and datapath next-state: commit, hold on stall, or boot
  always_comb begin
    pc_next        = pc_reg;
    state_next     = state_reg;
    redirect_next  = 1'b0;
    misalign_next  = misalign_reg;
    stall_cnt_next = stall_cnt_reg;
    case (state_reg)
      ST_BOOT: begin
        // BUSYWAIT is ignored here; the first fetch address is always 0
        pc_next    = RESET_VECTOR;
        state_next = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (bus.BUSYWAIT) begin
          // Hold the PC; nothing commits so no redirect or misalign update
          state_next = ST_STALL;
          if (stall_cnt_reg != STALL_CNT_MAX) begin
            stall_cnt_next = stall_cnt_reg + 8'd1;
          end
        end else begin
          // Commit using the inputs present at this edge
          pc_next       = sel.next_pc;
          state_next    = ST_RUN;
          redirect_next = sel.taken;
          misalign_next = misalign_reg | sel.misaligned;
        end
      end
      default: begin
        // Unreachable encoding: restart cleanly from BOOT
        pc_next    = RESET_VECTOR;
        state_next = ST_BOOT;
      end
    endcase
  end

  // State registers; reset overrides every other input including stalls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg        <= RESET_VECTOR;
      state_reg     <= ST_BOOT;
      redirect_reg  <= 1'b0;
      misalign_reg  <= 1'b0;
      stall_cnt_reg <= 8'd0;
    end else begin
      pc_reg        <= pc_next;
      state_reg     <= state_next;
      redirect_reg  <= redirect_next;
      misalign_reg  <= misalign_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign bus.PC        = pc_reg;
  assign bus.PC_PLUS4  = pc_plus4;
  assign bus.REDIRECT  = redirect_reg;
  assign bus.MISALIGN  = misalign_reg;
  assign bus.STALL_CNT = stall_cnt_reg;
  assign bus.STATE     = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer. Each table row is one
// clock edge: inputs applied before the edge, expected outputs after it.
// Build with PC_SEQ_BNE_EN defined to include the BRANCH_NE rows.
module tb_pc_sequencer;

  logic CLK;
  logic RESET;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        bw;
    logic        j;
    logic        beq;
    logic        z;
    logic        bne;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_rd;
    logic        e_mis;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic rst, bw, j, beq, z, bne,
                              input logic [31:0] tgt, e_pc,
                              input logic [1:0] e_st,
                              input logic e_rd, e_mis,
                              input logic [7:0] e_cnt);
    vec_t v;
    v.rst = rst; v.bw = bw; v.j = j; v.beq = beq; v.z = z; v.bne = bne;
    v.tgt = tgt; v.e_pc = e_pc; v.e_st = e_st; v.e_rd = e_rd;
    v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Drive one set of inputs away from the edge, then wait past the edge
  task automatic step(input logic rst, bw, j, beq, z, bne,
                      input logic [31:0] tgt);
    @(negedge CLK);
    RESET         = rst;
    bus.BUSYWAIT  = bw;
    bus.JUMP      = j;
    bus.BRANCH_EQ = beq;
    bus.ZERO      = z;
`ifdef PC_SEQ_BNE_EN
    bus.BRANCH_NE = bne;
`endif
    bus.TARGET    = tgt;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input int idx, input vec_t v);
    logic [31:0] exp_p4;
    exp_p4 = v.e_pc + 32'd4;
    check("pc",        idx, bus.PC,                v.e_pc);
    check("pc_plus4",  idx, bus.PC_PLUS4,          exp_p4);
    check("state",     idx, {30'd0, bus.STATE},    {30'd0, v.e_st});
    check("redirect",  idx, {31'd0, bus.REDIRECT}, {31'd0, v.e_rd});
    check("misalign",  idx, {31'd0, bus.MISALIGN}, {31'd0, v.e_mis});
    check("stall_cnt", idx, {24'd0, bus.STALL_CNT},{24'd0, v.e_cnt});
  endtask

  initial begin
    RESET = 1'b1;
    bus.BUSYWAIT = 1'b0; bus.JUMP = 1'b0; bus.BRANCH_EQ = 1'b0;
    bus.ZERO = 1'b0; bus.TARGET = 32'h0;
`ifdef PC_SEQ_BNE_EN
    bus.BRANCH_NE = 1'b0;
`endif

    //             rst bw j  beq z  bne tgt          e_pc         st  rd mis cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 0, 0));   // reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 0, 0));   // BOOT holds 0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h4,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h8,       1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h10,      32'h10,      1, 1, 0, 0));   // jump to 0x10
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 32'h40,      32'h40,      1, 1, 0, 0));   // beq taken
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h44,      1, 0, 0, 0));   // pulse ends
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h10,      32'h10,      1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h40,      32'h14,      1, 0, 0, 0));   // beq not taken
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h20,      32'h20,      1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h80,      32'h20,      2, 0, 0, 1));   // stall 1
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h80,      32'h20,      2, 0, 0, 2));   // stall 2
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h80,      32'h20,      2, 0, 0, 3));   // stall 3
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h80,      32'h80,      1, 1, 0, 3));   // release, jump
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h84,      1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h43,      32'h40,      1, 1, 1, 3));   // misaligned jump
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h44,      1, 0, 1, 3));   // sticky
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h48,      1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h100,     32'h100,     1, 1, 1, 3));   // jump beats beq
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h200,     32'h0,       0, 0, 0, 0));   // reset beats jump
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 0, 0));   // BUSYWAIT ignored in BOOT
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,       32'h0,       2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 0, 0));   // reset mid-stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h43,      32'h0,       2, 0, 0, 1));   // stalled misaligned: no flag
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h43,      32'h4,       1, 0, 0, 1));   // untaken misaligned: no flag
`ifdef PC_SEQ_BNE_EN
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100,     32'h100,     1, 1, 0, 1));   // bne taken
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h200,     32'h104,     1, 0, 0, 1));   // bne not taken
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].bw, vecs[i].j, vecs[i].beq, vecs[i].z,
           vecs[i].bne, vecs[i].tgt);
      $display("step %0d rst=%0b bw=%0b j=%0b beq=%0b z=%0b tgt=%h -> pc=%h st=%0d rd=%0b mis=%0b cnt=%0d",
               i, vecs[i].rst, vecs[i].bw, vecs[i].j, vecs[i].beq, vecs[i].z,
               vecs[i].tgt, bus.PC, bus.STATE, bus.REDIRECT, bus.MISALIGN,
               bus.STALL_CNT);
      check_all(i, vecs[i]);
    end

    // PC+4 wraps from the top of the address space with no flag
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    $display("wrap jump -> pc=%h pc_plus4=%h", bus.PC, bus.PC_PLUS4);
    check("wrap_pc",    100, bus.PC,       32'hFFFF_FFFC);
    check("wrap_plus4", 100, bus.PC_PLUS4, 32'h0000_0000);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    $display("wrap step -> pc=%h mis=%0b rd=%0b", bus.PC, bus.MISALIGN, bus.REDIRECT);
    check("wrap_next",  101, bus.PC,                32'h0000_0000);
    check("wrap_mis",   101, {31'd0, bus.MISALIGN}, 32'd0);
    check("wrap_rd",    101, {31'd0, bus.REDIRECT}, 32'd0);

    // Stall counter saturates at 255 while the PC keeps holding
    step(0, 0, 0, 0, 0, 0, 32'h0);   // PC = 4
    for (int k = 0; k < 260; k++) begin
      step(0, 1, 0, 0, 0, 0, 32'h0);
    end
    $display("long stall -> pc=%h cnt=%0d st=%0d", bus.PC, bus.STALL_CNT, bus.STATE);
    check("sat_cnt",   102, {24'd0, bus.STALL_CNT}, 32'd255);
    check("sat_pc",    102, bus.PC,                 32'h4);
    check("sat_state", 102, {30'd0, bus.STATE},     32'd2);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    $display("release -> pc=%h cnt=%0d st=%0d", bus.PC, bus.STALL_CNT, bus.STATE);
    check("sat_release_pc",  103, bus.PC,                 32'h8);
    check("sat_release_cnt", 103, {24'd0, bus.STALL_CNT}, 32'd255);
    check("sat_release_st",  103, {30'd0, bus.STATE},     32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
